// File: rtl/pc_pkg.sv
// Shared encodings and default sizes for the program counter block.
// Pure declarations: no logic, no latency, no flow control.
// PC_RAS_EN (build macro) selects whether the return-address stack exists.
package pc_pkg;

    localparam int ADDR_W_DEF    = 16;
    localparam int IMM_W_DEF     = 11;
    localparam int RAS_DEPTH_DEF = 4;

    typedef enum logic [1:0] {
        BR_EQ = 2'd0,
        BR_NE = 2'd1,
        BR_LT = 2'd2,
        BR_GE = 2'd3
    } br_cond_t;

    typedef enum logic [1:0] {
        PCSRC_INC = 2'd0,
        PCSRC_BR  = 2'd1,
        PCSRC_JMP = 2'd2,
        PCSRC_RST = 2'd3
    } pc_src_t;

endpackage

// File: rtl/pc_unit_if.sv
// Control/flag/address bundle between control FSM and PC block.
// Wires only; timing is set by the pc_unit register.
// No backpressure: the PC block accepts every qualified update.
interface pc_unit_if
    import pc_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int IMM_W  = IMM_W_DEF
);
    logic              PCWrite;
    logic              Branch;
    br_cond_t          BrCond;
    logic              Zero;
    logic              Neg;
    logic [ADDR_W-1:0] PCInA;
    logic [IMM_W-1:0]  IRIn;
    logic [ADDR_W-1:0] PCInC;
    pc_src_t           PCSrc;
    logic              Call;
    logic              Ret;
    logic [ADDR_W-1:0] PCOut;
    logic              RasEmpty;
    logic              RasFull;
    logic              RasErr;

    modport master (
        output PCWrite, Branch, BrCond, Zero, Neg, PCInA, IRIn, PCInC, PCSrc, Call, Ret,
        input  PCOut, RasEmpty, RasFull, RasErr
    );

    modport slave (
        input  PCWrite, Branch, BrCond, Zero, Neg, PCInA, IRIn, PCInC, PCSrc, Call, Ret,
        output PCOut, RasEmpty, RasFull, RasErr
    );
endinterface

// File: rtl/pc_ras.sv
// Return-address LIFO: push, pop, replace-top; oldest entry dropped on overflow.
// Latency: one cycle, top/depth/flags registered on the operation edge.
// No backpressure: over/underflow are absorbed and reported on the sticky err.
module pc_ras #(
    parameter int DEPTH = 4,
    parameter int W     = 16,
    parameter int DW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic          repl,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  top,
    output logic [DW-1:0] depth,
    output logic          full,
    output logic          empty,
    output logic          err
);

    // Index 0 holds the oldest entry; the live top sits at depth-1.
    logic [W-1:0] stk [DEPTH];

    assign full  = (depth == DW'(DEPTH));
    assign empty = (depth == '0);

    always_comb begin
        top = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (DW'(i + 1) == depth) top = stk[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            depth <= '0;
            err   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) stk[i] <= '0;
        end else if (push) begin
            if (full) begin
                for (int i = 0; i < DEPTH - 1; i++) stk[i] <= stk[i + 1];
                stk[DEPTH - 1] <= din;
                err            <= 1'b1;
            end else begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (DW'(i) == depth) stk[i] <= din;
                end
                depth <= depth + DW'(1);
            end
        end else if (pop) begin
            if (empty) err <= 1'b1;
            else       depth <= depth - DW'(1);
        end else if (repl) begin
            if (empty) begin
                err <= 1'b1;
            end else begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (DW'(i + 1) == depth) stk[i] <= din;
                end
            end
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Program counter with branch conditions and optional return-address stack (PC_RAS_EN).
// Latency: PCOut and RAS flags update one cycle after the qualifying edge.
// No backpressure: every load is taken; idle cycles hold PC and stack.
module pc_unit
    import pc_pkg::*;
#(
    parameter int                ADDR_W    = ADDR_W_DEF,
    parameter int                IMM_W     = IMM_W_DEF,
    parameter int                RAS_DEPTH = RAS_DEPTH_DEF,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0
) (
    input  logic     CLK,
    input  logic     reset,
    pc_unit_if.slave pc_if
);

    logic              cond;
    logic              load;
    logic [ADDR_W-1:0] br_tgt;
    logic [ADDR_W-1:0] mux_pc;
    logic [ADDR_W-1:0] next_pc;
    logic [ADDR_W-1:0] pc_q;

    always_comb begin
        cond = 1'b0;
        case (pc_if.BrCond)
            BR_EQ: cond = pc_if.Zero;
            BR_NE: cond = ~pc_if.Zero;
            BR_LT: cond = pc_if.Neg;
            BR_GE: cond = ~pc_if.Neg;
            default: cond = 1'b0;
        endcase
    end

    assign load = pc_if.PCWrite | (pc_if.Branch & cond);

    // Zero-extend then shift left by one; bits beyond ADDR_W fall off.
    generate
        if (ADDR_W > IMM_W + 1) begin : g_br_wide
            assign br_tgt = {{(ADDR_W - IMM_W - 1){1'b0}}, pc_if.IRIn, 1'b0};
        end else if (ADDR_W == IMM_W + 1) begin : g_br_fit
            assign br_tgt = {pc_if.IRIn, 1'b0};
        end else begin : g_br_trunc
            assign br_tgt = {pc_if.IRIn[ADDR_W-2:0], 1'b0};
        end
    endgenerate

    always_comb begin
        mux_pc = RESET_VEC;
        case (pc_if.PCSrc)
            PCSRC_INC: mux_pc = pc_if.PCInA;
            PCSRC_BR:  mux_pc = br_tgt;
            PCSRC_JMP: mux_pc = pc_if.PCInC;
            PCSRC_RST: mux_pc = RESET_VEC;
            default:   mux_pc = RESET_VEC;
        endcase
    end

`ifdef PC_RAS_EN
    localparam int DW = $clog2(RAS_DEPTH + 1);

    logic [ADDR_W-1:0] ras_top;
    logic [DW-1:0]     ras_depth;
    logic              ras_full;
    logic              ras_empty;
    logic              ras_err;

    pc_ras #(
        .DEPTH (RAS_DEPTH),
        .W     (ADDR_W),
        .DW    (DW)
    ) u_ras (
        .clk   (CLK),
        .reset (reset),
        .push  (load & pc_if.Call & ~pc_if.Ret),
        .pop   (load & pc_if.Ret & ~pc_if.Call),
        .repl  (load & pc_if.Call & pc_if.Ret),
        .din   (pc_if.PCInA),
        .top   (ras_top),
        .depth (ras_depth),
        .full  (ras_full),
        .empty (ras_empty),
        .err   (ras_err)
    );

    // Return wins over the PCSrc mux; an empty stack sends us to the reset vector.
    always_comb begin
        next_pc = mux_pc;
        if (pc_if.Ret) next_pc = ras_empty ? RESET_VEC : ras_top;
    end

    assign pc_if.RasEmpty = (ras_depth == '0);
    assign pc_if.RasFull  = ras_full;
    assign pc_if.RasErr   = ras_err;
`else
    assign next_pc        = mux_pc;
    assign pc_if.RasEmpty = 1'b1;
    assign pc_if.RasFull  = 1'b0;
    assign pc_if.RasErr   = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (reset)     pc_q <= RESET_VEC;
        else if (load) pc_q <= next_pc;
    end

    assign pc_if.PCOut = pc_q;

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit; RAS scenarios run only when PC_RAS_EN is defined.
module tb_pc_unit;
    import pc_pkg::*;

    logic CLK = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 CLK = ~CLK;

    pc_unit_if #(.ADDR_W(16), .IMM_W(11)) bus ();

    pc_unit #(
        .ADDR_W    (16),
        .IMM_W     (11),
        .RAS_DEPTH (4),
        .RESET_VEC (16'h0000)
    ) dut (
        .CLK   (CLK),
        .reset (reset),
        .pc_if (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle_in();
        bus.PCWrite = 1'b0; bus.Branch = 1'b0; bus.BrCond = BR_EQ;
        bus.Zero = 1'b0; bus.Neg = 1'b0; bus.PCInA = '0; bus.IRIn = '0;
        bus.PCInC = '0; bus.PCSrc = PCSRC_INC; bus.Call = 1'b0; bus.Ret = 1'b0;
    endtask

    // Apply one cycle of inputs, then sample 1 ns after the rising edge.
    task automatic op(input logic pw, input logic br, input br_cond_t bc,
                      input logic z, input logic n, input logic [15:0] a,
                      input logic [10:0] ir, input logic [15:0] c, input pc_src_t src,
                      input logic call, input logic ret);
        bus.PCWrite = pw; bus.Branch = br; bus.BrCond = bc; bus.Zero = z; bus.Neg = n;
        bus.PCInA = a; bus.IRIn = ir; bus.PCInC = c; bus.PCSrc = src;
        bus.Call = call; bus.Ret = ret;
        @(posedge CLK);
        #1;
        idle_in();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge CLK);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        logic [15:0] ret_exp [4];
        ret_exp[0] = 16'h000A; ret_exp[1] = 16'h0008;
        ret_exp[2] = 16'h0006; ret_exp[3] = 16'h0004;

        reset = 1'b0;
        idle_in();
        #2;
        do_reset();
        chk("rst_pc", bus.PCOut, 32'h0);
        chk("rst_empty", bus.RasEmpty, 32'h1);
        chk("rst_full", bus.RasFull, 32'h0);
        chk("rst_err", bus.RasErr, 32'h0);

        for (int i = 0; i < 3; i++) begin
            op(0, 0, BR_EQ, 0, 0, 16'h0, 11'h0, 16'h0, PCSRC_INC, 0, 0);
            chk("idle_pc", bus.PCOut, 32'h0);
            chk("idle_empty", bus.RasEmpty, 32'h1);
        end

        op(1, 0, BR_EQ, 0, 0, 16'h0002, 11'h0, 16'h0, PCSRC_INC, 0, 0);
        chk("seq_inc", bus.PCOut, 32'h0002);
        op(1, 0, BR_EQ, 0, 0, 16'h0004, 11'h0, 16'h1234, PCSRC_JMP, 0, 0);
        chk("seq_jmp", bus.PCOut, 32'h1234);

        op(0, 1, BR_NE, 1, 0, 16'h0, 11'h005, 16'h0, PCSRC_BR, 0, 0);
        chk("bne_hold", bus.PCOut, 32'h1234);
        op(0, 1, BR_NE, 0, 0, 16'h0, 11'h005, 16'h0, PCSRC_BR, 0, 0);
        chk("bne_take", bus.PCOut, 32'h000A);
        op(0, 1, BR_LT, 0, 1, 16'h0, 11'h7FF, 16'h0, PCSRC_BR, 0, 0);
        chk("blt_take", bus.PCOut, 32'h0FFE);
        op(0, 1, BR_GE, 0, 1, 16'h0, 11'h003, 16'h0, PCSRC_BR, 0, 0);
        chk("bge_hold", bus.PCOut, 32'h0FFE);
        op(0, 1, BR_EQ, 1, 1, 16'h0, 11'h003, 16'h0, PCSRC_BR, 0, 0);
        chk("beq_take", bus.PCOut, 32'h0006);
        op(1, 0, BR_EQ, 0, 0, 16'h0, 11'h0, 16'h0, PCSRC_RST, 0, 0);
        chk("src_rst", bus.PCOut, 32'h0000);

`ifdef PC_RAS_EN
        op(1, 0, BR_EQ, 0, 0, 16'h0010, 11'h0, 16'h0200, PCSRC_JMP, 1, 0);
        chk("call_pc", bus.PCOut, 32'h0200);
        chk("call_empty", bus.RasEmpty, 32'h0);
        op(1, 0, BR_EQ, 0, 0, 16'h0, 11'h0, 16'h0300, PCSRC_JMP, 0, 1);
        chk("ret_pc", bus.PCOut, 32'h0010);
        chk("ret_empty", bus.RasEmpty, 32'h1);
        op(0, 1, BR_EQ, 0, 0, 16'h0022, 11'h0, 16'h0400, PCSRC_JMP, 1, 0);
        chk("call_noload_pc", bus.PCOut, 32'h0010);
        chk("call_noload_empty", bus.RasEmpty, 32'h1);

        for (int i = 1; i <= 5; i++) begin
            op(1, 0, BR_EQ, 0, 0, 16'(2 * i), 11'h0, 16'h0100, PCSRC_JMP, 1, 0);
            if (i == 4) begin
                chk("ovf_full4", bus.RasFull, 32'h1);
                chk("ovf_err4", bus.RasErr, 32'h0);
            end
        end
        chk("ovf_full", bus.RasFull, 32'h1);
        chk("ovf_err", bus.RasErr, 32'h1);
        for (int i = 0; i < 4; i++) begin
            op(1, 0, BR_EQ, 0, 0, 16'h0, 11'h0, 16'h0, PCSRC_INC, 0, 1);
            chk("ovf_ret", bus.PCOut, 32'(ret_exp[i]));
        end
        chk("ovf_drain_empty", bus.RasEmpty, 32'h1);
        chk("ovf_err_sticky", bus.RasErr, 32'h1);

        do_reset();
        chk("err_clr", bus.RasErr, 32'h0);
        op(1, 0, BR_EQ, 0, 0, 16'h0, 11'h0, 16'h0300, PCSRC_JMP, 0, 0);
        chk("pre_udf", bus.PCOut, 32'h0300);
        op(1, 0, BR_EQ, 0, 0, 16'h0, 11'h0, 16'h0500, PCSRC_JMP, 0, 1);
        chk("udf_pc", bus.PCOut, 32'h0000);
        chk("udf_err", bus.RasErr, 32'h1);
        chk("udf_empty", bus.RasEmpty, 32'h1);

        do_reset();
        op(1, 0, BR_EQ, 0, 0, 16'h0040, 11'h0, 16'h0600, PCSRC_JMP, 1, 0);
        op(1, 0, BR_EQ, 0, 0, 16'h0050, 11'h0, 16'h0700, PCSRC_JMP, 1, 1);
        chk("cr_pc", bus.PCOut, 32'h0040);
        chk("cr_empty", bus.RasEmpty, 32'h0);
        op(1, 0, BR_EQ, 0, 0, 16'h0, 11'h0, 16'h0, PCSRC_INC, 0, 1);
        chk("cr_top", bus.PCOut, 32'h0050);
        chk("cr_depth1", bus.RasEmpty, 32'h1);
        chk("cr_err", bus.RasErr, 32'h0);

        op(1, 0, BR_EQ, 0, 0, 16'h0060, 11'h0, 16'h0800, PCSRC_JMP, 1, 0);
        reset = 1'b1;
        op(1, 0, BR_EQ, 0, 0, 16'h0070, 11'h0, 16'h0900, PCSRC_JMP, 1, 0);
        reset = 1'b0;
        chk("rst_mid_pc", bus.PCOut, 32'h0000);
        chk("rst_mid_empty", bus.RasEmpty, 32'h1);
        op(1, 0, BR_EQ, 0, 0, 16'h0, 11'h0, 16'h0A00, PCSRC_JMP, 0, 1);
        chk("rst_mid_udf_pc", bus.PCOut, 32'h0000);
        chk("rst_mid_udf_err", bus.RasErr, 32'h1);
`else
        op(1, 0, BR_EQ, 0, 0, 16'h0010, 11'h0, 16'h0200, PCSRC_JMP, 1, 0);
        chk("norad_call_pc", bus.PCOut, 32'h0200);
        chk("norad_call_empty", bus.RasEmpty, 32'h1);
        op(1, 0, BR_EQ, 0, 0, 16'h0022, 11'h0, 16'h0, PCSRC_INC, 0, 1);
        chk("norad_ret_pc", bus.PCOut, 32'h0022);
        chk("norad_full", bus.RasFull, 32'h0);
        chk("norad_err", bus.RasErr, 32'h0);
        op(1, 0, BR_EQ, 0, 0, 16'h0024, 11'h0, 16'h0, PCSRC_INC, 1, 1);
        chk("norad_cr_pc", bus.PCOut, 32'h0024);
        reset = 1'b1;
        op(1, 0, BR_EQ, 0, 0, 16'h0030, 11'h0, 16'h0, PCSRC_INC, 0, 0);
        reset = 1'b0;
        chk("rst_mid_pc", bus.PCOut, 32'h0000);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
Parametrised successor of the accumulator CPU's program counter block. Holds the PC register and selects the next PC from the incremented PC, a zero-extended shifted branch immediate, a jump/register target or the reset vector. Adds four selectable branch conditions and a hardware return-address stack (RAS) for call/return. Sits between the control FSM, the ALU flags and instruction memory addressing.

Parameters:
ADDR_W, 16, PC and target width in bits
IMM_W, 11, branch immediate width taken from the instruction register
RAS_DEPTH, 4, return-address stack entries, 2..16
RESET_VEC, 16'h0000, PC value after reset and PCSrc=3 target (ADDR_W bits)

Ports:
CLK  in  1  rising-edge clock, the block's only clock
reset  in  1  synchronous, active-high reset
PCWrite  in  1  unconditional PC update enable
Branch  in  1  conditional update enable, qualified by BrCond
BrCond  in  2  0=beq(Zero), 1=bne(~Zero), 2=blt(Neg), 3=bge(~Neg)
Zero  in  1  ALU zero flag
Neg  in  1  ALU sign flag
PCInA  in  ADDR_W  incremented PC (PC+2); also the call return address
IRIn  in  IMM_W  branch immediate
PCInC  in  ADDR_W  jump/register target
PCSrc  in  2  0=PCInA, 1=ZE(IRIn)<<1, 2=PCInC, 3=RESET_VEC
Call  in  1  push PCInA onto the RAS when the PC is loaded
Ret  in  1  next PC = RAS top, then pop
PCOut  out  ADDR_W  current PC
RasEmpty  out  1  RAS depth == 0
RasFull  out  1  RAS depth == RAS_DEPTH
RasErr  out  1  sticky overflow/underflow flag

Behaviour:
- Reset: PCOut=RESET_VEC, RAS depth=0, RasEmpty=1, RasFull=0, RasErr=0. Reset overrides every other input in the same cycle, including an operation already in progress.
- Condition: cond = BrCond-selected flag. load = PCWrite | (Branch & cond). All state updates happen only on a rising CLK edge where load=1. When load=0, the PC and RAS hold.
- Branch target: zero-extend IRIn to ADDR_W, shift left by 1, truncate to ADDR_W. Bit IMM_W-1 lands at bit IMM_W and is dropped if ADDR_W <= IMM_W.
- Next PC priority: Ret > PCSrc mux. With Ret=1, PCOut <= RAS top and PCSrc is ignored.
- Call (load & Call & ~Ret): PC <= mux(PCSrc). Push PCInA. If the stack is full, discard the oldest entry, keep depth at RAS_DEPTH and set RasErr.
- Ret (load & Ret & ~Call): pop. If the stack is empty, PC <= RESET_VEC, depth stays 0 and RasErr is set.
- Call & Ret together with load: PC <= top and the top entry is replaced with PCInA; depth is unchanged. If the stack is empty, follow the Ret-underflow rule and do not push.
- Call or Ret with load=0: no effect.
- Latency: PCOut reflects the new value one cycle after the qualifying edge. Flags are registered and update on the same edge as the RAS.
- RasErr is cleared only by reset.

Optional Feature:
PC_RAS_EN.
- Defined: RAS and RasErr behave as described above.
- Undefined: no RAS storage. Call and Ret are ignored and the next PC always comes from the PCSrc mux. RasEmpty=1, RasFull=0 and RasErr=0 constantly.

Decomposition:
- Shared package pc_pkg holds:
  - BrCond encodings: BR_EQ, BR_NE, BR_LT, BR_GE.
  - PCSrc encodings: PCSRC_INC, PCSRC_BR, PCSRC_JMP, PCSRC_RST.
  - Default ADDR_W, IMM_W and RAS_DEPTH constants.
- One natural sub-module, pc_ras: a parametrised LIFO with push, pop, replace, top, depth, full, empty and err outputs.
- The PC register and next-PC mux stay in pc_unit.

Test Plan:
- Reset then idle: reset=1 for 1 cycle, then all enables 0 for 3 cycles -> PCOut=0x0000 and RasEmpty=1 throughout; reset asserted mid-call -> PCOut=0x0000 and depth=0 next cycle.
- Sequential update: PCWrite=1, PCSrc=0, PCInA=0x0002 -> PCOut=0x0002 next cycle; PCSrc=2, PCInC=0x1234 -> PCOut=0x1234.
- Branch conditions:
  - Branch=1, PCSrc=1, IRIn=0x005, BrCond=bne, Zero=1 -> PC holds.
  - Same inputs with Zero=0 -> PCOut=0x000A.
  - BrCond=blt, Neg=1, IRIn=0x7FF -> PCOut=0x0FFE.
- Call/return: Call with PCInA=0x0010, PCInC=0x0200, PCSrc=2 -> PCOut=0x0200 and depth 1; later Ret -> PCOut=0x0010 and RasEmpty=1.
- Overflow: 5 Calls with RAS_DEPTH=4 pushing 0x2, 0x4, 0x6, 0x8, 0xA -> RasFull=1 and RasErr=1; 4 Rets return 0xA, 0x8, 0x6, 0x4.
- Underflow and simultaneous events:
  - Ret on an empty stack -> PCOut=RESET_VEC and RasErr=1.
  - Call+Ret with top=0x0040 and PCInA=0x0050 -> PCOut=0x0040, top=0x0050, depth unchanged.
